// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester cache-line memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } req_type_e;

  localparam logic REQ_ICA = 1'b0;
  localparam logic REQ_DCA = 1'b1;

  localparam int WAIT_W = 16;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the instruction and data cache requesters.
// Fixed data-cache priority by default; MEM_ARB_RR_EN adds a priority input for round-robin.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_valid,
`ifdef MEM_ARB_RR_EN
  input  logic       i_prio,
`endif
  output logic       o_any,
  output logic       o_idx
);

  always_comb begin
    o_any = |i_valid;
`ifdef MEM_ARB_RR_EN
    // i_prio names the requester that was not granted last; it only matters on a tie
    if (i_valid == 2'b11) o_idx = i_prio;
    else                  o_idx = i_valid[1] ? REQ_DCA : REQ_ICA;
`else
    o_idx = i_valid[1] ? REQ_DCA : REQ_ICA;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester cache-line memory arbiter with timeout on the memory acknowledge.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed data-cache priority.
//
// state   | meaning
// IDLE    | waiting for any requester; latches winner and payload
// BUSY    | memory request driven, counting wait cycles
// RESP    | one-cycle o_req_ack to the winner (o_req_err on timeout)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 i_req_valid,
  input  logic [1:0]                 i_req_type,
  input  logic [1:0][ADDR_WIDTH-1:0] i_req_addr,
  input  logic [1:0][LINE_WIDTH-1:0] i_req_data,
  output logic [1:0]                 o_req_ack,
  output logic                       o_req_err,
  output logic [LINE_WIDTH-1:0]      o_req_rdata,
  output logic                       o_mem_enable,
  output logic                       o_mem_type,
  output logic [ADDR_WIDTH-1:0]      o_mem_addr,
  output logic [LINE_WIDTH-1:0]      o_mem_data,
  input  logic                       i_mem_ack,
  input  logic [LINE_WIDTH-1:0]      i_mem_data
);

  localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic                   win_q, win_d;
  req_type_e              type_q, type_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LINE_WIDTH-1:0]  data_q, data_d;
  logic                   en_q, en_d;
  logic [1:0]             ack_q, ack_d;
  logic                   err_q, err_d;
  logic [LINE_WIDTH-1:0]  rdata_q, rdata_d;
  logic [WAIT_W-1:0]      cnt_q, cnt_d;
  logic                   pick_any, pick_idx;

`ifdef MEM_ARB_RR_EN
  logic ptr_q, ptr_d;
`endif

  mem_arb_pick u_pick (
    .i_valid (i_req_valid),
`ifdef MEM_ARB_RR_EN
    .i_prio  (ptr_q),
`endif
    .o_any   (pick_any),
    .o_idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    type_d  = type_q;
    addr_d  = addr_q;
    data_d  = data_q;
    en_d    = en_q;
    ack_d   = 2'b00;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
`ifdef MEM_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          win_d   = pick_idx;
          type_d  = req_type_e'(i_req_type[pick_idx]);
          addr_d  = i_req_addr[pick_idx];
          data_d  = i_req_data[pick_idx];
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUSY;
`ifdef MEM_ARB_RR_EN
          ptr_d   = ~pick_idx;
`endif
        end
      end
      ST_BUSY: begin
        // a real acknowledge beats a timeout landing in the same cycle
        if (i_mem_ack) begin
          if (type_q == MEM_READ) rdata_d = i_mem_data;
          en_d          = 1'b0;
          ack_d[win_q]  = 1'b1;
          state_d       = ST_RESP;
        end else if (cnt_q == TMO_LAST) begin
          en_d          = 1'b0;
          ack_d[win_q]  = 1'b1;
          err_d         = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      win_q   <= REQ_ICA;
      type_q  <= MEM_READ;
      addr_q  <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      ack_q   <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
`ifdef MEM_ARB_RR_EN
      ptr_q   <= REQ_DCA;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
`ifdef MEM_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign o_req_ack    = ack_q;
  assign o_req_err    = err_q;
  assign o_req_rdata  = rdata_q;
  assign o_mem_enable = en_q;
  assign o_mem_type   = type_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_data   = data_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, physical address width of memory requests.
REQ-002 Parameter LINE_WIDTH, default 128, width of one cache-line transfer.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, maximum cycles spent waiting for i_mem_ack; legal range 2..65535.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 i_req_valid  input  2  request valid per requester; bit 0 = instruction cache, bit 1 = data cache.
REQ-007 i_req_type  input  2  per requester: 0 read line, 1 write line.
REQ-008 i_req_addr  input  2 x ADDR_WIDTH  per-requester line address.
REQ-009 i_req_data  input  2 x LINE_WIDTH  per-requester write data.
REQ-010 o_req_ack  output  2  one-cycle completion pulse per requester.
REQ-011 o_req_err  output  1  timeout flag, valid only with an o_req_ack pulse.
REQ-012 o_req_rdata  output  LINE_WIDTH  registered read data, valid with o_req_ack.
REQ-013 o_mem_enable, o_mem_type, o_mem_addr, o_mem_data  output  1/1/ADDR_WIDTH/LINE_WIDTH  memory request channel.
REQ-014 i_mem_ack, i_mem_data  input  1/LINE_WIDTH  memory completion pulse and read data.

Function
REQ-015 The arbiter SHALL implement states IDLE, BUSY, RESP in an FSM.
REQ-016 IDLE: if any i_req_valid bit is set, the arbiter SHALL latch the winner index and its type/addr/data and move to BUSY at the next edge.
REQ-017 Arbitration without MEM_ARB_RR_EN: data cache (bit 1) SHALL win over instruction cache (bit 0).
REQ-018 BUSY: o_mem_enable SHALL be 1 with o_mem_type/addr/data held stable from the latched values until i_mem_ack.
REQ-019 BUSY with i_mem_ack=1: the arbiter SHALL capture i_mem_data (reads only; writes leave o_req_rdata unchanged) and move to RESP.
REQ-020 RESP lasts exactly one cycle: o_req_ack[winner]=1, o_mem_enable=0; the next state SHALL be IDLE.
REQ-021 Latency: request seen in IDLE at cycle N -> o_mem_enable at N+1; i_mem_ack at cycle M -> o_req_ack at M+1; IDLE at M+2.
REQ-022 Requesters hold valid and payload stable until ack; a valid withdrawn during BUSY SHALL be ignored and the transaction completed.
REQ-023 A 16-bit wait counter SHALL clear on BUSY entry and increment each BUSY cycle without i_mem_ack.
REQ-024 When the counter reaches TIMEOUT_CYCLES-1 without i_mem_ack, the arbiter SHALL drop o_mem_enable, move to RESP, and assert o_req_err with the ack.
REQ-025 i_mem_ack in the same cycle as timeout SHALL win: normal completion, o_req_err=0.
REQ-026 i_mem_ack outside BUSY SHALL be ignored.
REQ-027 At most one o_req_ack bit SHALL be set in any cycle.

Reset
REQ-028 On rst low, asynchronously: state IDLE; o_req_ack=0, o_req_err=0, o_req_rdata=0, o_mem_enable=0, o_mem_type=0, o_mem_addr=0, o_mem_data=0; wait counter 0; RR pointer pointing at data cache.
REQ-029 Reset during BUSY SHALL abandon the transaction with no ack issued.

Configuration
REQ-030 Macro MEM_ARB_RR_EN defined: on simultaneous requests the requester not granted last SHALL win; the pointer updates at each grant.
REQ-031 Macro MEM_ARB_RR_EN undefined: fixed priority per REQ-017; no pointer register is synthesised.

Structure
REQ-032 Package mem_arb_pkg SHALL hold the FSM state enum, the request-type enum (MEM_READ=0, MEM_WRITE=1) and the requester index constants (REQ_ICA=0, REQ_DCA=1).
REQ-033 A sub-module mem_arb_pick SHALL implement the winner selection (fixed or round-robin), keeping the FSM in mem_arbiter.

Verification
REQ-034 DCA read addr 0x100, mem ack 3 cycles later with data 0xA5..A5 -> o_mem_addr=0x100 from N+1, o_req_ack=2'b10 and rdata 0xA5..A5 one cycle after the mem ack.
REQ-035 Both valid in the same cycle, no macro -> DCA granted first, then ICA; with MEM_ARB_RR_EN, four back-to-back dual requests -> grants DCA, ICA, DCA, ICA.
REQ-036 TIMEOUT_CYCLES=4, no mem ack -> o_mem_enable high 4 cycles, then o_req_ack plus o_req_err=1, state back to IDLE.
REQ-037 TIMEOUT_CYCLES=4, mem ack on the 4th BUSY cycle -> normal ack, o_req_err=0.
REQ-038 rst pulsed low mid-BUSY -> all outputs 0 immediately, no ack; a new ICA write after release completes normally.
